// File: rtl/regfile_arb_pkg.sv
// Shared widths and the write-request record used by the regfile write arbiter and its host FIFO.
package regfile_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wr_req_t;
endpackage

// File: rtl/write_req_fifo.sv
// Synchronous, non-fall-through FIFO of register write requests.
// Full and empty are told apart by the extra occupancy bit; pointers wrap modulo DEPTH.
module write_req_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         ctrl_reset_n,
  input  logic         i_push,
  input  wr_req_t      i_req,
  input  logic         i_pop,
  output wr_req_t      o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [PTR_W:0] o_count
);

  wr_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage is not reset: pointer reset alone discards stale contents.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_req;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-write-port initiator for the 32x32 regfile: processor writeback has priority, host writes queue in a FIFO.
// Optional macro REGFILE_ARB_PROTECT_EN drops host writes to r1..PROT_LIMIT and pulses host_err.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int PROT_LIMIT   = 1
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic                    wb_we,
  input  logic [REG_ADDR_W-1:0]   wb_reg,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    wb_stall,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [REG_ADDR_W-1:0]   host_reg,
  input  logic [DATA_W-1:0]       host_data,
  output logic                    host_err,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]   ctrl_writeReg,
  output logic [DATA_W-1:0]       data_writeReg
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PROT_LIMIT < 0 || PROT_LIMIT > 31) begin : g_bad_param
    $error("regfile_write_arbiter: DEPTH must be a power of two >= 2 and PROT_LIMIT in 0..31");
  end

  wr_req_t          w_head;
  wr_req_t          w_host_req;
  wr_req_t          w_issue_req;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_wb_req;
  logic             w_forced;
  logic             w_prot;
  logic             r_active;
  logic [SC_W-1:0]  r_starve_cnt;
  logic             r_we;
  wr_req_t          r_out;

  assign w_host_req.reg_addr = host_reg;
  assign w_host_req.data     = host_data;

  // r_active keeps host_ready low and blocks issue until the first edge after reset release.
  assign host_ready = r_active && !w_full;
  assign w_accept   = host_valid && host_ready;
  assign w_push     = w_accept && (host_reg != ZERO_REG) && !w_prot;
  assign w_wb_req   = wb_we && (wb_reg != ZERO_REG);
  assign w_forced   = (r_starve_cnt == SC_W'(STARVE_LIMIT)) && !w_empty;
  assign wb_stall   = w_forced;

  always_comb begin
    w_issue     = 1'b0;
    w_pop       = 1'b0;
    w_issue_req = w_head;
    if (r_active) begin
      if (w_forced) begin
        w_issue = 1'b1;
        w_pop   = 1'b1;
      end else if (w_wb_req) begin
        w_issue              = 1'b1;
        w_issue_req.reg_addr = wb_reg;
        w_issue_req.data     = wb_data;
      end else if (!w_empty) begin
        w_issue = 1'b1;
        w_pop   = 1'b1;
      end
    end
  end

  write_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .i_push       (w_push),
    .i_req        (w_host_req),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (pending)
  );

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_active     <= 1'b0;
      r_starve_cnt <= '0;
      r_we         <= 1'b0;
      r_out        <= '0;
    end else begin
      r_active <= 1'b1;
      r_we     <= w_issue;
      if (w_issue) r_out <= w_issue_req;
      // A non-empty FIFO that is not popped can only mean writeback won this cycle.
      if (w_empty || w_pop)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != SC_W'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_out.reg_addr;
  assign data_writeReg    = r_out.data;

`ifdef REGFILE_ARB_PROTECT_EN
  logic r_host_err;

  assign w_prot   = (host_reg != ZERO_REG) && (host_reg <= REG_ADDR_W'(PROT_LIMIT));
  assign host_err = r_host_err;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) r_host_err <= 1'b0;
    else               r_host_err <= w_accept && w_prot;
  end
`else
  assign w_prot   = 1'b0;
  assign host_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int PROT_LIMIT   = 1;
`ifdef REGFILE_ARB_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   ctrl_reset_n = 1'b1;
  logic                   wb_we = 1'b0;
  logic [4:0]             wb_reg = '0;
  logic [31:0]            wb_data = '0;
  logic                   wb_stall;
  logic                   host_valid = 1'b0;
  logic                   host_ready;
  logic [4:0]             host_reg = '0;
  logic [31:0]            host_data = '0;
  logic                   host_err;
  logic [$clog2(DEPTH):0] pending;
  logic                   ctrl_writeEnable;
  logic [4:0]             ctrl_writeReg;
  logic [31:0]            data_writeReg;

  regfile_write_arbiter #(
    .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .PROT_LIMIT(PROT_LIMIT)
  ) dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
    .host_valid(host_valid), .host_ready(host_ready), .host_reg(host_reg),
    .host_data(host_data), .host_err(host_err), .pending(pending),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending host writes as a queue, plus the spec-level starvation count.
  wr_req_t     mq[$];
  int          m_starve;
  bit          m_active;
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic        exp_err;
  bit          d_issue, d_pop, d_push, d_forced, d_ready, d_accept, d_err;
  wr_req_t     d_req;
  bit          last_stall, last_blocked;

  function automatic void model_reset();
    mq.delete();
    m_starve = 0;
    m_active = 0;
    exp_we = 0; exp_reg = '0; exp_data = '0; exp_err = 0;
  endfunction

  function automatic void model_decide();
    bit prot;
    d_issue = 0; d_pop = 0; d_req = '0;
    d_ready  = m_active && (mq.size() < DEPTH);
    d_accept = host_valid && d_ready;
    d_forced = m_active && (mq.size() > 0) && (m_starve == STARVE_LIMIT);
    if (m_active) begin
      if (d_forced) begin
        d_issue = 1; d_pop = 1; d_req = mq[0];
      end else if (wb_we && wb_reg != 0) begin
        d_issue = 1; d_req.reg_addr = wb_reg; d_req.data = wb_data;
      end else if (mq.size() > 0) begin
        d_issue = 1; d_pop = 1; d_req = mq[0];
      end
    end
    prot   = PROT_ON && (host_reg >= 1) && (host_reg <= PROT_LIMIT);
    d_push = d_accept && (host_reg != 0) && !prot;
    d_err  = d_accept && prot;
  endfunction

  function automatic void model_commit();
    bit was_empty;
    wr_req_t e;
    was_empty = (mq.size() == 0);
    exp_we = d_issue;
    if (d_issue) begin
      exp_reg  = d_req.reg_addr;
      exp_data = d_req.data;
    end
    if (d_pop) void'(mq.pop_front());
    if (d_push) begin
      e.reg_addr = host_reg;
      e.data     = host_data;
      mq.push_back(e);
    end
    if (was_empty || d_pop) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    exp_err  = d_err;
    m_active = 1;
  endfunction

  // Called at posedge+1; drives one cycle of inputs and checks both combinational and registered outputs.
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic hv, input logic [4:0] hr, input logic [31:0] hd);
    wb_we = we; wb_reg = wr; wb_data = wd;
    host_valid = hv; host_reg = hr; host_data = hd;
    #1;
    model_decide();
    chk("wb_stall", wb_stall, d_forced);
    chk("host_ready", host_ready, d_ready);
    chk("pending", pending, mq.size());
    last_stall   = d_forced;
    last_blocked = hv && !d_ready;
    @(posedge clock);
    #1;
    model_commit();
    chk("ctrl_writeEnable", ctrl_writeEnable, exp_we);
    chk("ctrl_writeReg", ctrl_writeReg, exp_reg);
    chk("data_writeReg", data_writeReg, exp_data);
    chk("host_err", host_err, exp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    ctrl_reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_reg", ctrl_writeReg, 0);
    chk("rst_data", data_writeReg, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", host_ready, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_err", host_err, 0);
    @(posedge clock);
    #1;
    chk("rst_hold_we", ctrl_writeEnable, 0);
    chk("rst_hold_ready", host_ready, 0);
    ctrl_reset_n = 1'b1;
    last_stall = 0;
    last_blocked = 0;
  endtask

  int first_stall;
  int n_acc;
  int max_pend;
  int wp, hp;

  initial begin
    #3;
    do_reset();
    // Write presented in the reset-release cycle must not issue.
    step(1, 5'd9, 32'h1234_5678, 1, 5'd9, 32'h0);
    chk("release_no_issue", ctrl_writeEnable, 0);
    idle(3);

    // Host only
    step(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("host_only_we", ctrl_writeEnable, 1);
    chk("host_only_reg", ctrl_writeReg, 5);
    chk("host_only_data", data_writeReg, 32'hDEAD_BEEF);
    chk("host_only_pending", pending, 0);
    idle(2);

    // Priority of writeback over a queued host write
    step(0, 0, 0, 1, 5'd4, 32'h22);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd3, 32'h11, 0, 0, 0);
      chk("prio_wb_reg", ctrl_writeReg, 3);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("prio_host_reg", ctrl_writeReg, 4);
    chk("prio_host_data", data_writeReg, 32'h22);
    idle(2);

    // Starvation guard
    step(0, 0, 0, 1, 5'd7, 32'hAA);
    first_stall = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1, 5'd9, 32'h99, 0, 0, 0);
      if (last_stall && first_stall < 0) first_stall = i;
      if (i == 9) begin
        chk("starve_reg", ctrl_writeReg, 7);
        chk("starve_data", data_writeReg, 32'hAA);
      end
      if (i == 10) chk("starve_wb_after", ctrl_writeReg, 9);
    end
    chk("starve_cycle", first_stall, 9);
    idle(2);

    // Full FIFO / backpressure with writeback held constant
    n_acc = 0;
    max_pend = 0;
    for (int i = 0; i < 30; i++) begin
      if (n_acc < 5) step(1, 5'd2, 32'h2, 1, 5'(10 + n_acc), 32'(n_acc + 100));
      else           step(1, 5'd2, 32'h2, 0, 0, 0);
      if (d_accept) n_acc++;
      if (mq.size() > max_pend) max_pend = mq.size();
    end
    chk("full_accepted", n_acc, 5);
    chk("full_max_pending", max_pend, DEPTH);
    idle(8);
    chk("full_drained", pending, 0);

    // Zero register and protected register
    step(0, 0, 0, 1, 5'd0, 32'h5555);
    chk("zero_pending", pending, 0);
    step(0, 0, 0, 1, 5'd1, 32'h7777);
    chk("prot_err", host_err, PROT_ON);
    step(0, 0, 0, 0, 0, 0);
    chk("prot_we", ctrl_writeEnable, !PROT_ON);
    idle(2);

    // Reset mid-operation with three queued host entries
    for (int i = 0; i < 3; i++) step(1, 5'd6, 32'h66, 1, 5'(20 + i), 32'(i));
    chk("pre_reset_pending", pending, 3);
    do_reset();
    step(1, 5'd8, 32'h88, 1, 5'd8, 32'h88);
    chk("post_reset_we", ctrl_writeEnable, 0);
    idle(4);
    chk("post_reset_idle_we", ctrl_writeEnable, 0);

    // Randomized traffic in phases of differing load
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin wp = 20;  hp = 50; end
        1: begin wp = 95;  hp = 90; end
        2: begin wp = 60;  hp = 30; end
        default: begin wp = 100; hp = 80; end
      endcase
      for (int c = 0; c < 400; c++) begin
        logic we_n, hv_n;
        logic [4:0] wr_n, hr_n;
        logic [31:0] wd_n, hd_n;
        we_n = wb_we; wr_n = wb_reg; wd_n = wb_data;
        hv_n = host_valid; hr_n = host_reg; hd_n = host_data;
        if (!last_stall) begin
          we_n = ($urandom_range(0, 99) < wp);
          wr_n = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          wd_n = $urandom;
        end
        if (!last_blocked) begin
          hv_n = ($urandom_range(0, 99) < hp);
          hr_n = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
          hd_n = $urandom;
        end
        if (ph == 2 && c == 200) do_reset();
        step(we_n, wr_n, wd_n, hv_n, hr_n, hd_n);
      end
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
